// File: rtl/buffet_linebuf_ctrl.sv
// Line-buffer controller that streams image rows into a buffet and issues
// column-major window reads followed by one row-sized shrink per output row.
module buffet_linebuf_ctrl #(
  parameter int IDX_W = 16,
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int WIN_H = 3,
  parameter int CAP   = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             buf_push_valid,
  input  logic             buf_push_ready,
  output logic [IDX_W-1:0] rd_idx,
  output logic             rd_idx_valid,
  input  logic             rd_idx_ready,
  output logic             shrink_valid,
  output logic [IDX_W-1:0] shrink_size,
  input  logic             shrink_ready,
  output logic [IDX_W-1:0] occ
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILL   = 3'd1,
    ST_READ   = 3'd2,
    ST_SHRINK = 3'd3,
    ST_FLUSH  = 3'd4
  } state_e;

  localparam logic [IDX_W-1:0] ONE_L      = IDX_W'(1);
  localparam logic [IDX_W-1:0] IMG_W_L    = IDX_W'(IMG_W);
  localparam logic [IDX_W-1:0] CAP_L      = IDX_W'(CAP);
  localparam logic [IDX_W-1:0] TOTAL_L    = IDX_W'(IMG_W * IMG_H);
  localparam logic [IDX_W-1:0] FILL_THR_L = IDX_W'((WIN_H - 1) * IMG_W + 1);
  localparam logic [IDX_W-1:0] R_LAST_L   = IDX_W'(WIN_H - 1);
  localparam logic [IDX_W-1:0] X_LAST_L   = IDX_W'(IMG_W - 1);
  localparam logic [IDX_W-1:0] ROW_END_L  = IDX_W'(IMG_H - WIN_H + 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] occ_q, occ_d;
  logic [IDX_W-1:0] pushed_q, pushed_d;
  logic [IDX_W-1:0] x_q, x_d;
  logic [IDX_W-1:0] r_q, r_d;
  logic [IDX_W-1:0] row_q, row_d;
  logic             done_q, done_d;

  logic             busy_s;
  logic             in_ready_s;
  logic             push_s;
  logic [IDX_W-1:0] rd_idx_s;
  logic             rd_valid_s;
  logic             rd_hs_s;
  logic             shrink_valid_s;
  logic             shrink_hs_s;

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      occ_q    <= '0;
      pushed_q <= '0;
      x_q      <= '0;
      r_q      <= '0;
      row_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      occ_q    <= occ_d;
      pushed_q <= pushed_d;
      x_q      <= x_d;
      r_q      <= r_d;
      row_q    <= row_d;
      done_q   <= done_d;
    end
  end

  // Next-state and counter updates.
  always_comb begin
    state_d  = state_q;
    occ_d    = occ_q + (push_s ? ONE_L : '0) - (shrink_hs_s ? IMG_W_L : '0);
    pushed_d = pushed_q + (push_s ? ONE_L : '0);
    x_d      = x_q;
    r_d      = r_q;
    row_d    = row_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_FILL;
          occ_d    = '0;
          pushed_d = '0;
          x_d      = '0;
          r_d      = '0;
          row_d    = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      // occ_d lets the first window read appear the cycle after the enabling push.
      ST_FILL: state_d = (occ_d >= FILL_THR_L) ? ST_READ : ST_FILL;
      ST_READ: begin
        if (rd_hs_s) begin
          if (r_q != R_LAST_L) begin
            r_d = r_q + ONE_L;
          end else if (x_q != X_LAST_L) begin
            r_d = '0;
            x_d = x_q + ONE_L;
          end else begin
            state_d = ST_SHRINK;
            row_d   = row_q + ONE_L;
          end
        end else begin
          state_d = ST_READ;
        end
      end
      ST_SHRINK: begin
        if (shrink_hs_s) begin
          x_d     = '0;
          r_d     = '0;
          state_d = (row_q < ROW_END_L) ? ST_READ : ST_FLUSH;
        end else begin
          state_d = ST_SHRINK;
        end
      end
      ST_FLUSH: begin
        if (occ_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake qualifiers and buffet-facing outputs.
  always_comb begin
    busy_s         = (state_q != ST_IDLE);
    in_ready_s     = busy_s && buf_push_ready && (occ_q < CAP_L) && (pushed_q < TOTAL_L);
    push_s         = in_valid && in_ready_s;
    rd_idx_s       = r_q * IMG_W_L + x_q;
    rd_valid_s     = 1'b0;
    shrink_valid_s = 1'b0;
    case (state_q)
      // occ > idx is occ >= idx+1 without the extra adder overflow.
      ST_READ:   rd_valid_s     = (occ_q > rd_idx_s);
      ST_SHRINK: shrink_valid_s = 1'b1;
      ST_FLUSH:  shrink_valid_s = (occ_q != '0);
      default: begin
        rd_valid_s     = 1'b0;
        shrink_valid_s = 1'b0;
      end
    endcase
    rd_hs_s     = rd_valid_s && rd_idx_ready;
    shrink_hs_s = shrink_valid_s && shrink_ready;
  end

  assign busy           = busy_s;
  assign done           = done_q;
  assign in_ready       = in_ready_s;
  assign buf_push_valid = push_s;
  assign rd_idx         = rd_idx_s;
  assign rd_idx_valid   = rd_valid_s;
  assign shrink_valid   = shrink_valid_s;
  assign shrink_size    = IMG_W_L;
  assign occ            = occ_q;

endmodule

// File: tb/tb_buffet_linebuf_ctrl.sv
// Randomized bench for buffet_linebuf_ctrl against a counting model of the
// frame: words pushed, window reads issued, rows released.
module tb_buffet_linebuf_ctrl;

  localparam int IDX_W = 16;
  localparam int IMG_W = 4;
  localparam int IMG_H = 4;
  localparam int WIN_H = 3;
  localparam int CAP   = 16;
  localparam int TOTAL = IMG_W * IMG_H;
  localparam int RPR   = WIN_H * IMG_W;
  localparam int ROWS  = IMG_H - WIN_H + 1;
  localparam int THR   = (WIN_H - 1) * IMG_W + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             busy;
  logic             done;
  logic             in_valid;
  logic             in_ready;
  logic             buf_push_valid;
  logic             buf_push_ready;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_idx_valid;
  logic             rd_idx_ready;
  logic             shrink_valid;
  logic [IDX_W-1:0] shrink_size;
  logic             shrink_ready;
  logic [IDX_W-1:0] occ;

  int checks = 0;
  int errors = 0;

  bit m_active, m_started, m_done;
  int m_occ, m_pushes, m_reads, m_shrinks;
  int hold_cnt;

  buffet_linebuf_ctrl #(
    .IDX_W(IDX_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .WIN_H(WIN_H), .CAP(CAP)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .buf_push_valid(buf_push_valid),
    .buf_push_ready(buf_push_ready), .rd_idx(rd_idx), .rd_idx_valid(rd_idx_valid),
    .rd_idx_ready(rd_idx_ready), .shrink_valid(shrink_valid), .shrink_size(shrink_size),
    .shrink_ready(shrink_ready), .occ(occ)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active  = 1'b0;
    m_started = 1'b0;
    m_done    = 1'b0;
    m_occ     = 0;
    m_pushes  = 0;
    m_reads   = 0;
    m_shrinks = 0;
  endtask

  // One clock: drive inputs, check outputs against the model, advance the model.
  task automatic step(input int mode, input bit do_start, input bit do_rst, input bit chk_idx0);
    bit e_rdv, e_shv, e_inr, e_fin, push, rdh, shh;
    int k, e_idx, rows_read;
    @(negedge clk);
    k         = m_reads % RPR;
    e_idx     = (k % WIN_H) * IMG_W + k / WIN_H;
    rows_read = m_reads / RPR;
    e_rdv = 1'b0;
    e_shv = 1'b0;
    e_fin = 1'b0;
    if (m_active && m_started) begin
      if (m_shrinks < rows_read) e_shv = 1'b1;
      else if (rows_read < ROWS) e_rdv = (m_occ >= e_idx + 1);
      else begin
        e_shv = (m_occ != 0);
        e_fin = (m_occ == 0);
      end
    end
    rst   = do_rst;
    start = do_start;
    case (mode)
      0: begin
        in_valid = 1'b1; buf_push_ready = 1'b1; rd_idx_ready = 1'b1; shrink_ready = 1'b1;
      end
      2: begin
        in_valid = 1'b1; buf_push_ready = 1'b1; shrink_ready = 1'b1;
        rd_idx_ready = !(e_rdv && e_idx == 5 && hold_cnt < 5);
        if (e_rdv && e_idx == 5 && hold_cnt < 5) hold_cnt++;
      end
      4: begin
        in_valid = (m_pushes < 12) || e_shv || (m_shrinks > 0);
        buf_push_ready = 1'b1; rd_idx_ready = 1'b1; shrink_ready = 1'b1;
      end
      default: begin
        in_valid       = ($urandom_range(0, 3) != 0);
        buf_push_ready = ($urandom_range(0, 3) != 0);
        rd_idx_ready   = ($urandom_range(0, 2) != 0);
        shrink_ready   = ($urandom_range(0, 2) != 0);
      end
    endcase
    e_inr = m_active && buf_push_ready && (m_occ < CAP) && (m_pushes < TOTAL);
    #1;
    check_val("busy", int'(busy), int'(m_active));
    check_val("done", int'(done), int'(m_done));
    check_val("in_ready", int'(in_ready), int'(e_inr));
    check_val("push_valid", int'(buf_push_valid), int'(in_valid && e_inr));
    check_val("occ", int'(occ), m_occ);
    check_val("rd_idx_valid", int'(rd_idx_valid), int'(e_rdv));
    check_val("shrink_valid", int'(shrink_valid), int'(e_shv));
    if (e_rdv) check_val("rd_idx", int'(rd_idx), e_idx);
    if (e_shv) check_val("shrink_size", int'(shrink_size), IMG_W);
    if (chk_idx0) check_val("rd_idx_reset", int'(rd_idx), 0);
    push = in_valid && e_inr;
    rdh  = e_rdv && rd_idx_ready;
    shh  = e_shv && shrink_ready;
    if (do_rst) begin
      model_reset();
    end else if (!m_active) begin
      m_done = 1'b0;
      if (do_start) begin
        model_reset();
        m_active = 1'b1;
      end
    end else begin
      m_done    = e_fin;
      m_active  = !e_fin;
      m_occ     = m_occ + int'(push) - (shh ? IMG_W : 0);
      m_pushes  = m_pushes + int'(push);
      m_reads   = m_reads + int'(rdh);
      m_shrinks = m_shrinks + int'(shh);
      if (m_occ >= THR) m_started = 1'b1;
    end
  endtask

  task automatic run_frame(input int mode);
    hold_cnt = 0;
    step(mode, 1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 400; n++) begin
      if (mode == 3 && m_active && m_started && m_reads == 6) begin
        step(mode, 1'b0, 1'b1, 1'b0);
        step(mode, 1'b0, 1'b0, 1'b1);
        return;
      end
      step(mode, (mode == 1) && ($urandom_range(0, 15) == 0), 1'b0, 1'b0);
      if (!m_active && m_done) return;
    end
    check_val("frame_timeout", 0, 1);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    buf_push_ready = 1'b0;
    rd_idx_ready = 1'b0;
    shrink_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    step(0, 1'b0, 1'b0, 1'b1);
    run_frame(0);
    run_frame(2);
    run_frame(4);
    run_frame(3);
    run_frame(0);
    for (int f = 0; f < 8; f++) run_frame(1);
    run_frame(3);
    run_frame(1);
    step(0, 1'b0, 1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
